// File: rtl/wakeup_qualifier.sv
// wakeup_qualifier: synchronises the comparator output, matches an N-pulse
// signature (width window, bounded gaps) and drives a held wake_up level.
// In : clki, rst (sync, active high), comp_in (async), enable,
//      min_width, max_width, max_gap [W_W], n_pulses [8]
// Out: wake_up, busy, pulse_cnt [8], wu_total [16]
// Option: define WU_GLITCH_FILTER_EN for a 3-tap majority spike filter.
module wakeup_qualifier #(
    parameter int HOLD_CYCLES = 4,
    parameter int LOCKOUT     = 100000,
    parameter int W_W         = 16
) (
    input  logic           clki,
    input  logic           rst,
    input  logic           comp_in,
    input  logic           enable,
    input  logic [W_W-1:0] min_width,
    input  logic [W_W-1:0] max_width,
    input  logic [W_W-1:0] max_gap,
    input  logic [7:0]     n_pulses,
    output logic           wake_up,
    output logic           busy,
    output logic [7:0]     pulse_cnt,
    output logic [15:0]    wu_total
);
    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam int LW = $clog2(LOCKOUT + 1);
    localparam logic [HW-1:0]  HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [LW-1:0]  LOCK_LAST = LW'(LOCKOUT - 1);
    localparam logic [HW-1:0]  H_ONE     = HW'(1);
    localparam logic [LW-1:0]  L_ONE     = LW'(1);
    localparam logic [W_W-1:0] W_ONE     = W_W'(1);
    localparam logic [W_W-1:0] W_SAT     = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HIGH,
        S_GAP,
        S_WAIT_LOW,
        S_FIRE,
        S_LOCK
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic           s1;
    logic           s2;
    logic           s3;
    logic           lvl;
    logic           lvl_d;
    logic           rise;
    logic           fall;
    logic           width_ok;
    logic           fire_entry;
    logic [W_W-1:0] width_cnt;
    logic [W_W-1:0] width_nxt;
    logic [W_W-1:0] gap_cnt;
    logic [W_W-1:0] gap_nxt;
    logic [HW-1:0]  hold_cnt;
    logic [HW-1:0]  hold_nxt;
    logic [LW-1:0]  lock_cnt;
    logic [LW-1:0]  lock_nxt;
    logic [7:0]     pc_nxt;
    logic [7:0]     need;
    logic [8:0]     pc_inc;

    always_ff @(posedge clki) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= comp_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

`ifdef WU_GLITCH_FILTER_EN
    logic s4;
    logic lvl_q;

    always_ff @(posedge clki) begin
        if (rst) begin
            s4    <= 1'b0;
            lvl_q <= 1'b0;
        end else begin
            s4    <= s3;
            lvl_q <= lvl;
        end
    end

    // Two of three consecutive samples must agree, so a lone
    // one-cycle spike never reaches the edge detector.
    assign lvl   = (s2 & s3) | (s2 & s4) | (s3 & s4);
    assign lvl_d = lvl_q;
`else
    assign lvl   = s2;
    assign lvl_d = s3;
`endif

    assign rise     = lvl & ~lvl_d;
    assign fall     = ~lvl & lvl_d;
    assign need     = (n_pulses == 8'd0) ? 8'd1 : n_pulses;
    assign pc_inc   = {1'b0, pulse_cnt} + 9'd1;
    assign width_ok = (width_cnt >= min_width) &&
                      (width_cnt <= max_width);

    always_comb begin
        state_nxt = state;
        width_nxt = width_cnt;
        gap_nxt   = gap_cnt;
        hold_nxt  = hold_cnt;
        lock_nxt  = lock_cnt;
        pc_nxt    = pulse_cnt;
        if (!enable) begin
            state_nxt = S_IDLE;
            width_nxt = '0;
            gap_nxt   = '0;
            hold_nxt  = '0;
            lock_nxt  = '0;
            pc_nxt    = '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (rise) begin
                        state_nxt = S_HIGH;
                        width_nxt = W_ONE;
                    end
                end
                S_HIGH: begin
                    // Thresholds use the count before this cycle.
                    if (fall) begin
                        if (!width_ok) begin
                            state_nxt = S_IDLE;
                            pc_nxt    = '0;
                        end else if (pc_inc >= {1'b0, need}) begin
                            state_nxt = S_FIRE;
                            pc_nxt    = '0;
                            hold_nxt  = '0;
                        end else begin
                            state_nxt = S_GAP;
                            pc_nxt    = pc_inc[7:0];
                            gap_nxt   = W_ONE;
                        end
                    end else if (width_cnt > max_width) begin
                        state_nxt = S_WAIT_LOW;
                        pc_nxt    = '0;
                    end else if (width_cnt != W_SAT) begin
                        width_nxt = width_cnt + W_ONE;
                    end
                end
                S_GAP: begin
                    // Timeout wins over a rise on the same cycle.
                    if (gap_cnt > max_gap) begin
                        state_nxt = S_IDLE;
                        pc_nxt    = '0;
                    end else if (rise) begin
                        state_nxt = S_HIGH;
                        width_nxt = W_ONE;
                    end else if (gap_cnt != W_SAT) begin
                        gap_nxt = gap_cnt + W_ONE;
                    end
                end
                S_WAIT_LOW: begin
                    if (!lvl) state_nxt = S_IDLE;
                end
                S_FIRE: begin
                    if (hold_cnt >= HOLD_LAST) begin
                        state_nxt = S_LOCK;
                        lock_nxt  = '0;
                    end else begin
                        hold_nxt = hold_cnt + H_ONE;
                    end
                end
                S_LOCK: begin
                    // A level still high on exit gives no rise.
                    if (lock_cnt >= LOCK_LAST) begin
                        state_nxt = S_IDLE;
                    end else begin
                        lock_nxt = lock_cnt + L_ONE;
                    end
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    assign fire_entry = (state_nxt == S_FIRE) && (state != S_FIRE);

    always_ff @(posedge clki) begin
        if (rst) begin
            state     <= S_IDLE;
            width_cnt <= '0;
            gap_cnt   <= '0;
            hold_cnt  <= '0;
            lock_cnt  <= '0;
            pulse_cnt <= '0;
            wake_up   <= 1'b0;
            wu_total  <= '0;
        end else begin
            state     <= state_nxt;
            width_cnt <= width_nxt;
            gap_cnt   <= gap_nxt;
            hold_cnt  <= hold_nxt;
            lock_cnt  <= lock_nxt;
            pulse_cnt <= pc_nxt;
            wake_up   <= (state_nxt == S_FIRE);
            if (fire_entry && (wu_total != 16'hFFFF)) begin
                wu_total <= wu_total + 16'd1;
            end
        end
    end

    assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_wakeup_qualifier.sv
// tb_wakeup_qualifier: directed and random signatures against a
// flag-based behavioural model of the wake-up qualifier.
module tb_wakeup_qualifier;
    localparam int HOLD = 4;
    localparam int LOCK = 1000;

    logic        clki = 1'b0;
    logic        rst = 1'b1;
    logic        comp_in = 1'b0;
    logic        enable = 1'b1;
    logic [15:0] min_width = 16'd40;
    logic [15:0] max_width = 16'd60;
    logic [15:0] max_gap = 16'd100;
    logic [7:0]  n_pulses = 8'd3;
    logic        wake_up;
    logic        busy;
    logic [7:0]  pulse_cnt;
    logic [15:0] wu_total;

    int n_chk = 0;
    int n_pass = 0;
    bit chk_en = 1'b0;
    int cnt;

    // model: synchroniser samples plus activity flags
    bit m_s1, m_s2, m_s3, m_s4, m_fq;
    bit in_pulse, in_gap, draining;
    int hi_len, lo_len, m_pc, hold_left, lock_left, m_total;

    wakeup_qualifier #(
        .HOLD_CYCLES(HOLD),
        .LOCKOUT    (LOCK),
        .W_W        (16)
    ) dut (
        .clki     (clki),
        .rst      (rst),
        .comp_in  (comp_in),
        .enable   (enable),
        .min_width(min_width),
        .max_width(max_width),
        .max_gap  (max_gap),
        .n_pulses (n_pulses),
        .wake_up  (wake_up),
        .busy     (busy),
        .pulse_cnt(pulse_cnt),
        .wu_total (wu_total)
    );

    always #5 clki = ~clki;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t",
                      nm, act, exp, $time);
    endtask

    task automatic clear_activity();
        in_pulse = 0; in_gap = 0; draining = 0;
        hi_len = 0; lo_len = 0; m_pc = 0;
        hold_left = 0; lock_left = 0;
    endtask

    task automatic do_fire();
        m_pc = 0;
        in_pulse = 0;
        hold_left = HOLD;
        if (m_total < 65535) m_total++;
    endtask

    task automatic model_step();
        bit lvl, prev, rise, fall;
        int need;
        if (rst) begin
            m_s1 = 0; m_s2 = 0; m_s3 = 0; m_s4 = 0; m_fq = 0;
            clear_activity();
            m_total = 0;
            return;
        end
`ifdef WU_GLITCH_FILTER_EN
        lvl = (int'(m_s2) + int'(m_s3) + int'(m_s4)) >= 2;
        prev = m_fq;
`else
        lvl = m_s2;
        prev = m_s3;
`endif
        m_fq = lvl;
        m_s4 = m_s3; m_s3 = m_s2; m_s2 = m_s1; m_s1 = comp_in;
        rise = lvl && !prev;
        fall = !lvl && prev;
        need = (n_pulses == 0) ? 1 : int'(n_pulses);
        if (!enable) begin
            clear_activity();
        end else if (hold_left > 0) begin
            hold_left--;
            if (hold_left == 0) lock_left = LOCK;
        end else if (lock_left > 0) begin
            lock_left--;
        end else if (draining) begin
            if (!lvl) draining = 0;
        end else if (in_pulse) begin
            if (fall) begin
                in_pulse = 0;
                if (hi_len >= min_width && hi_len <= max_width) begin
                    if (m_pc + 1 >= need) do_fire();
                    else begin
                        m_pc++;
                        in_gap = 1;
                        lo_len = 1;
                    end
                end else m_pc = 0;
            end else if (hi_len > max_width) begin
                in_pulse = 0; draining = 1; m_pc = 0;
            end else if (hi_len < 65535) hi_len++;
        end else if (in_gap) begin
            if (lo_len > max_gap) begin
                in_gap = 0; m_pc = 0;
            end else if (rise) begin
                in_gap = 0; in_pulse = 1; hi_len = 1;
            end else if (lo_len < 65535) lo_len++;
        end else if (rise) begin
            in_pulse = 1; hi_len = 1;
        end
    endtask

    always @(negedge clki) begin
        if (chk_en) begin
            chk("wake_up", int'(wake_up), int'(hold_left > 0));
            chk("busy", int'(busy),
                int'(in_pulse || in_gap || draining ||
                     hold_left > 0 || lock_left > 0));
            chk("pulse_cnt", int'(pulse_cnt), m_pc);
            chk("wu_total", int'(wu_total), m_total);
        end
    end

    task automatic step(input bit c);
        comp_in = c;
        @(posedge clki);
        model_step();
        @(negedge clki);
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0);
    endtask

    task automatic pulse(input int hi, input int lo);
        repeat (hi) step(1'b1);
        repeat (lo) step(1'b0);
    endtask

    task automatic setcfg(input int mn, input int mx,
                          input int g, input int n);
        min_width = 16'(mn);
        max_width = 16'(mx);
        max_gap = 16'(g);
        n_pulses = 8'(n);
    endtask

    task automatic signature();
        pulse(50, 80);
        pulse(50, 80);
        pulse(50, 20);
    endtask

    initial begin
        // reset with comp_in toggling
        step(1'b1);
        chk_en = 1'b1;
        chk("rst_wake", int'(wake_up), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_pc", int'(pulse_cnt), 0);
        chk("rst_total", int'(wu_total), 0);
        step(1'b0);
        chk("rst2_wake", int'(wake_up), 0);
        chk("rst2_busy", int'(busy), 0);
        rst = 1'b0;
        idle(5);

        // three 50-cycle pulses, check latency and hold length
        pulse(50, 80);
        pulse(50, 80);
        chk("sig_pc2", int'(pulse_cnt), 2);
        chk("model_pc2", m_pc, 2);
        repeat (50) step(1'b1);
        step(1'b0);
        chk("lat_k", int'(wake_up), 0);
        step(1'b0);
        chk("lat_k1", int'(wake_up), 0);
`ifdef WU_GLITCH_FILTER_EN
        step(1'b0);
        chk("lat_k2_filt", int'(wake_up), 0);
`endif
        step(1'b0);
        chk("lat_fire", int'(wake_up), 1);
        cnt = 1;
        repeat (8) begin
            step(1'b0);
            if (wake_up) cnt++;
        end
        chk("hold_len", cnt, HOLD);
        chk("total1", int'(wu_total), 1);
        chk("model_total1", m_total, 1);
        idle(1100);

        // short middle pulse aborts the attempt
        pulse(50, 80);
        chk("short_pc1", int'(pulse_cnt), 1);
        pulse(30, 80);
        chk("short_pc0", int'(pulse_cnt), 0);
        chk("short_total", int'(wu_total), 1);
        signature();
        chk("after_short", int'(wu_total), 2);
        idle(1100);

        // gap timeout, over-long pulse, then exact boundaries
        pulse(50, 80);
        pulse(50, 101);
        pulse(50, 80);
        chk("gap_to_pc", int'(pulse_cnt), 0);
        chk("gap_to_total", int'(wu_total), 2);
        pulse(50, 80);
        pulse(61, 80);
        chk("long_pc", int'(pulse_cnt), 0);
        pulse(40, 100);
        chk("bnd_pc1", int'(pulse_cnt), 1);
        pulse(60, 100);
        chk("bnd_pc2", int'(pulse_cnt), 2);
        pulse(50, 20);
        chk("bnd_total", int'(wu_total), 3);
        idle(1100);

        // lockout hides a signature started 500 cycles after fire
        pulse(50, 80);
        pulse(50, 80);
        pulse(50, 500);
        chk("lock_total_a", int'(wu_total), 4);
        signature();
        chk("lock_ignored", int'(wu_total), 4);
        chk("lock_busy", int'(busy), 1);
        idle(300);
        signature();
        chk("lock_after", int'(wu_total), 5);
        idle(1100);

        // min above max never qualifies
        setcfg(60, 40, 100, 1);
        pulse(50, 20);
        chk("inv_total", int'(wu_total), 5);
        chk("inv_pc", int'(pulse_cnt), 0);

        // single-cycle spike, n_pulses = 0
        setcfg(1, 60, 100, 0);
        step(1'b1);
        idle(10);
`ifdef WU_GLITCH_FILTER_EN
        chk("spike", int'(wu_total), 5);
`else
        chk("spike", int'(wu_total), 6);
`endif
        idle(1100);

        // enable dropped mid-fire
        pulse(5, 0);
        repeat (4) step(1'b0);
        chk("mid_fire_wake", int'(wake_up), 1);
        enable = 1'b0;
        step(1'b0);
        chk("en_drop_wake", int'(wake_up), 0);
        chk("en_drop_busy", int'(busy), 0);
`ifdef WU_GLITCH_FILTER_EN
        chk("en_drop_total", int'(wu_total), 6);
`else
        chk("en_drop_total", int'(wu_total), 7);
`endif
        enable = 1'b1;
        idle(5);

        // random configurations and pulse trains
        for (int b = 0; b < 25; b++) begin
            int mn;
            enable = 1'b0;
            step(1'b0);
            mn = $urandom_range(1, 8);
            if ($urandom_range(0, 9) == 0)
                setcfg(mn, mn - 1, $urandom_range(2, 14),
                       $urandom_range(0, 4));
            else
                setcfg(mn, mn + $urandom_range(0, 8),
                       $urandom_range(2, 14), $urandom_range(0, 4));
            enable = 1'b1;
            if ($urandom_range(0, 9) == 0) begin
                rst = 1'b1;
                step(1'b1);
                rst = 1'b0;
            end
            for (int p = 0; p < 8; p++) begin
                pulse($urandom_range(1, 18), $urandom_range(1, 16));
                if ($urandom_range(0, 19) == 0) begin
                    enable = 1'b0;
                    step(1'b0);
                    enable = 1'b1;
                end
            end
            idle($urandom_range(20, 1100));
        end

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
